// File: rtl/synchronizer.sv
// Multi-flop CDC synchronizer: each bit of in passes through STAGES flops on the destination clock.
// Meant for Gray-coded pointers, where the source changes at most one bit per transfer.
module synchronizer #(
  parameter int               WIDTH       = 32,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Fewer than two flops gives no metastability protection, so reject it at elaboration.
  if (STAGES < 2 || STAGES > 4) begin : gen_bad_stages
    $error("synchronizer: STAGES must be in the range 2..4");
  end

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : gen_stage
    if (i == 0) begin : gen_first
      assign stage_d[i] = in;
    end else begin : gen_rest
      assign stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out = stage_q[STAGES-1];

endmodule

// File: tb/tb_synchronizer.sv
// Testbench for synchronizer: a 32-bit/2-stage instance and an 8-bit/3-stage instance,
// checked every clock edge against a due-edge scoreboard of driven values.
module tb_synchronizer;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] inA = '0;
  logic [31:0] outA;
  logic [7:0]  inB = '0;
  logic [7:0]  outB;

  logic [31:0] expA = '0;
  logic [7:0]  expB = '0;
  exp_t        qA[$];
  exp_t        qB[$];
  int          edgeCnt = 0;
  int          total = 0;
  int          bad = 0;

  synchronizer #(.WIDTH(32), .STAGES(2)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (inA),
    .out   (outA)
  );

  synchronizer #(.WIDTH(8), .STAGES(3)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (inB),
    .out   (outB)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, sample 1 ns later, and retire any scoreboard entries now due.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    edgeCnt++;
    while (qA.size() > 0 && qA[0].due <= edgeCnt) begin
      e = qA.pop_front();
      expA = e.val;
    end
    while (qB.size() > 0 && qB[0].due <= edgeCnt) begin
      e = qB.pop_front();
      expB = e.val[7:0];
    end
  endtask

  task automatic driveA(input logic [31:0] v);
    inA = v;
    qA.push_back('{due: edgeCnt + 2, val: v});
  endtask

  task automatic driveB(input logic [7:0] v);
    inB = v;
    qB.push_back('{due: edgeCnt + 3, val: {24'd0, v}});
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    qA.delete();
    qB.delete();
    expA = '0;
    expB = '0;
  endtask

  // After release, whatever sits on the inputs is captured by the next edge.
  task automatic releaseReset();
    rst_n = 1'b1;
    qA.push_back('{due: edgeCnt + 2, val: inA});
    qB.push_back('{due: edgeCnt + 3, val: {24'd0, inB}});
  endtask

  task automatic test_reset();
    #1 assertReset();
    #1;
    total++;
    if (outA !== 32'd0 || outB !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_async: outA=%h outB=%h required 0/0", outA, outB);
    end
    for (int i = 0; i < 2; i++) begin
      inA = $urandom;
      inB = 8'($urandom);
      tick();
      total++;
      if (outA !== 32'd0 || outB !== 8'd0) begin
        bad++;
        $display("[TB] FAIL reset_hold edge %0d: outA=%h outB=%h required 0/0", i, outA, outB);
      end
    end
    inA = '0;
    inB = '0;
    #1 releaseReset();
  endtask

  task automatic test_basic_latency();
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (outA !== expA) begin
        bad++;
        $display("[TB] FAIL basic_idle: outA=%h required %h", outA, expA);
      end
    end
    #1 driveA(32'd15);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (outA !== expA) begin
        bad++;
        $display("[TB] FAIL basic_latency edge %0d: outA=%h required %h", i, outA, expA);
      end
    end
  endtask

  task automatic test_value_update();
    tick();
    tick();
    #1 driveA(32'd22);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (outA !== expA) begin
        bad++;
        $display("[TB] FAIL value_update edge %0d: outA=%h required %h", i, outA, expA);
      end
    end
  endtask

  task automatic test_mid_reset();
    #1 driveA(32'hFFFF_FFFF);
    tick();
    total++;
    if (outA !== expA) begin
      bad++;
      $display("[TB] FAIL mid_reset_pre: outA=%h required %h", outA, expA);
    end
    #2 assertReset();
    #1;
    total++;
    if (outA !== 32'd0 || outB !== 8'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset_async: outA=%h outB=%h required 0/0", outA, outB);
    end
    #1 releaseReset();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outA !== expA || outB !== expB) begin
        bad++;
        $display("[TB] FAIL mid_reset_recover edge %0d: outA=%h outB=%h required %h/%h",
                 i, outA, outB, expA, expB);
      end
    end
  endtask

  task automatic test_param_sweep();
    #1 driveB(8'hA5);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (outB !== expB) begin
        bad++;
        $display("[TB] FAIL stages3_latency edge %0d: outB=%h required %h", i, outB, expB);
      end
    end
  endtask

  task automatic test_gray_walk();
    logic [3:0]  code;
    logic [3:0]  sentCodes[$];
    logic [31:0] seenA[$];
    logic [7:0]  seenB[$];
    logic [31:0] prevA;
    logic [7:0]  prevB;
    prevA = outA;
    prevB = outB;
    for (int i = 0; i < 16 + 2; i++) begin
      if (i < 16) begin
        code = 4'(i) ^ (4'(i) >> 1);
        sentCodes.push_back(code);
        #1;
        driveA({28'd0, code});
        driveB({4'd0, code});
      end
      for (int c = 0; c < 3; c++) begin
        tick();
        total++;
        if (outA !== expA || outB !== expB) begin
          bad++;
          $display("[TB] FAIL gray_walk step %0d cycle %0d: outA=%h outB=%h required %h/%h",
                   i, c, outA, outB, expA, expB);
        end
        if (outA !== prevA) seenA.push_back(outA);
        if (outB !== prevB) seenB.push_back(outB);
        prevA = outA;
        prevB = outB;
      end
    end
    total++;
    if (seenA.size() != 16 || seenB.size() != 16) begin
      bad++;
      $display("[TB] FAIL gray_walk_count: seenA=%0d seenB=%0d required 16/16",
               seenA.size(), seenB.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (seenA[i] !== {28'd0, sentCodes[i]} || seenB[i] !== {4'd0, sentCodes[i]}) begin
          bad++;
          $display("[TB] FAIL gray_walk_seq %0d: outA=%h outB=%h required %h",
                   i, seenA[i], seenB[i], sentCodes[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_value_update();
    test_mid_reset();
    test_param_sweep();
    test_gray_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion before 50000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
